// File: rtl/ocm_pkg.sv
// ocm_pkg: shared types and helpers for the pipelined on-chip memory slave.
//   state_t        - sequencer states (reset, zero-fill sweep, ready)
//   OCM_LAT_1/2    - the two supported read latencies
//   ocm_lanes      - number of byte lanes in a data word
//   ocm_par_width  - number of stored parity bits per word (0 when disabled)
package ocm_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam int OCM_LAT_1 = 1;
  localparam int OCM_LAT_2 = 2;

  function automatic int ocm_lanes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int ocm_par_width(input int data_w, input bit par_en);
    return par_en ? (data_w / 8) : 0;
  endfunction

endpackage

// File: rtl/ocm_ram_core.sv
// ocm_ram_core: single-port byte-lane RAM with registered read.
// Each lane is LANE_W bits wide (8 data bits, plus a parity bit when the
// parent stores parity), so a lane write always updates data and parity
// together.
//   clk, reset_n  - clock, async active-low reset (read register only)
//   we, be, addr  - write strobe, per-lane enables, word address
//   wdata         - write word, LANES*LANE_W bits
//   re            - read strobe; q loads mem[addr] and holds otherwise
//   q             - registered read word
// INIT_FILE names a hex preload that the tool flow attaches to the array.
module ocm_ram_core #(
  parameter int    LANES     = 4,
  parameter int    LANE_W    = 8,
  parameter int    ADDR_W    = 13,
  parameter string INIT_FILE = ""
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    we,
  input  logic [LANES-1:0]        be,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [LANES*LANE_W-1:0] wdata,
  input  logic                    re,
  output logic [LANES*LANE_W-1:0] q
);

  localparam int W     = LANES * LANE_W;
  localparam int DEPTH = 1 << ADDR_W;

  (* ram_init_file = INIT_FILE *) logic [W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // Output register only loads on a read so it holds between responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else if (re)  q <= mem[addr];
  end

endmodule

// File: rtl/ocm_avalon_pipelined.sv
// ocm_avalon_pipelined: parametrised Avalon-MM on-chip memory slave with
// pipelined reads (latency 1 or 2), optional post-reset zero-fill sweep and,
// when the OCM_PARITY_EN macro is defined, per-byte even parity with a sticky
// parity_err flag.
//   clk, reset_n         - clock, async active-low reset
//   address, byteenable  - word address, write lane enables
//   chipselect/read/write/writedata - Avalon request
//   clken                - global clock enable (low = stall everything)
//   reset_req            - quiesce: blocks new accepts, in-flight reads finish
//   readdata/readdatavalid - read response, in order
//   waitrequest          - high while a request cannot be accepted
//   parity_err           - (OCM_PARITY_EN only) sticky parity mismatch flag
module ocm_avalon_pipelined
  import ocm_pkg::*;
#(
  parameter int    DATA_W       = 32,
  parameter int    ADDR_W       = 13,
  parameter int    READ_LATENCY = 1,
  parameter int    INIT_CLEAR   = 0,
  parameter string INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_W-1:0]     writedata,
  input  logic                  clken,
  input  logic                  reset_req,
`ifdef OCM_PARITY_EN
  output logic                  parity_err,
`endif
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest
);

`ifdef OCM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int LANES    = ocm_lanes(DATA_W);
  localparam int LANE_W   = 8 + ocm_par_width(DATA_W, PAR_EN) / LANES;
  localparam int RAM_W    = LANES * LANE_W;
  localparam bit LAT2     = (READ_LATENCY != OCM_LAT_1);
  // The sequencer leaves reset straight into its working state so the sweep
  // is exactly 2**ADDR_W enabled cycles long.
  localparam state_t START_ST = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;

  // ---------------- sequencer ----------------
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic              in_clear, in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= START_ST;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      ST_RESET: state_next = START_ST;
      ST_CLEAR: begin
        if (clken) begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == '1) state_next = ST_READY;
        end
      end
      ST_READY: state_next = ST_READY;
      default:  state_next = START_ST;
    endcase
  end

  // reset_n is folded in so waitrequest reads high during reset even when
  // the register already holds ST_READY.
  always_comb begin
    in_clear = 1'b0;
    in_ready = 1'b0;
    if (reset_n) begin
      case (state_reg)
        ST_CLEAR: in_clear = 1'b1;
        ST_READY: in_ready = 1'b1;
        default:  ;
      endcase
    end
  end

  // ---------------- accept logic ----------------
  logic slot_open, write_acc, read_acc;

  assign slot_open   = in_ready & clken & ~reset_req;
  assign waitrequest = ~slot_open;
  assign write_acc   = slot_open & chipselect & write;
  assign read_acc    = slot_open & chipselect & read & ~write;

  // ---------------- RAM ----------------
  logic [DATA_W-1:0] wdata_mux;
  logic [RAM_W-1:0]  ram_wdata, ram_q, out_word;
  logic              out_valid;

  assign wdata_mux = in_clear ? '0 : writedata;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign ram_wdata[gi*LANE_W +: 8] = wdata_mux[gi*8 +: 8];
      assign readdata[gi*8 +: 8]       = out_word[gi*LANE_W +: 8];
`ifdef OCM_PARITY_EN
      assign ram_wdata[gi*LANE_W + 8]  = ^wdata_mux[gi*8 +: 8];
`endif
    end
  endgenerate

  ocm_ram_core #(
    .LANES     (LANES),
    .LANE_W    (LANE_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE ((INIT_CLEAR != 0) ? "" : INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (write_acc | (in_clear & clken)),
    .be      (in_clear ? {LANES{1'b1}} : byteenable),
    .addr    (in_clear ? clr_cnt_reg : address),
    .wdata   (ram_wdata),
    .re      (read_acc),
    .q       (ram_q)
  );

  // ---------------- read pipeline ----------------
  // v1 tracks the RAM output register; every stage freezes while clken=0.
  logic v1_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   v1_reg <= 1'b0;
    else if (clken) v1_reg <= read_acc;
  end

  generate
    if (LAT2) begin : g_lat2
      logic [RAM_W-1:0] q2_reg;
      logic             v2_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          q2_reg <= '0;
          v2_reg <= 1'b0;
        end else if (clken) begin
          v2_reg <= v1_reg;
          if (v1_reg) q2_reg <= ram_q;
        end
      end
      assign out_word  = q2_reg;
      assign out_valid = v2_reg;
    end else begin : g_lat1
      assign out_word  = ram_q;
      assign out_valid = v1_reg;
    end
  endgenerate

  // A response held across a stall is presented once clken returns; the
  // stage then advances on that same edge, so it is not repeated.
  assign readdatavalid = out_valid & clken;

`ifdef OCM_PARITY_EN
  // ---------------- parity check ----------------
  logic [LANES-1:0] par_bad;
  logic             par_hit, parity_err_reg;

  for (gi = 0; gi < LANES; gi++) begin : g_par
    assign par_bad[gi] = out_word[gi*LANE_W + 8] ^ (^out_word[gi*LANE_W +: 8]);
  end

  assign par_hit = readdatavalid & (|par_bad);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     parity_err_reg <= 1'b0;
    else if (par_hit) parity_err_reg <= 1'b1;
  end

  // Visible on the response cycle itself, then held by the sticky register.
  assign parity_err = parity_err_reg | par_hit;
`endif

endmodule

// File: tb/tb_ocm_avalon_pipelined.sv
// Bench for ocm_avalon_pipelined: one latency-1 and one latency-2 instance
// (ADDR_W=4, zero-fill enabled) share all inputs. A per-cycle vector table
// carries the expected outputs of both; the sweep, reset abort and parity
// cases are hand-written sequences.
module tb_ocm_avalon_pipelined;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n, chipselect, read, write, clken, reset_req;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic [DW-1:0] writedata;
  logic [DW-1:0] rd1, rd2;
  logic          rv1, rv2, wt1, wt2;
`ifdef OCM_PARITY_EN
  logic          pe1, pe2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ocm_avalon_pipelined #(
    .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1), .INIT_CLEAR(1), .INIT_FILE("")
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req),
`ifdef OCM_PARITY_EN
    .parity_err(pe1),
`endif
    .readdata(rd1), .readdatavalid(rv1), .waitrequest(wt1)
  );

  ocm_avalon_pipelined #(
    .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2), .INIT_CLEAR(1), .INIT_FILE("")
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req),
`ifdef OCM_PARITY_EN
    .parity_err(pe2),
`endif
    .readdata(rd2), .readdatavalid(rv2), .waitrequest(wt2)
  );

  typedef struct {
    logic          cs, rd, wr, ck, rq;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic          ew;
    logic          v1;
    logic [31:0]   d1;
    logic          v2;
    logic [31:0]   d2;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic cs, rd, wr, ck, rq, input logic [AW-1:0] a,
                     input logic [3:0] be, input logic [31:0] wd, input logic ew,
                     input logic v1, input logic [31:0] d1, input logic v2, input logic [31:0] d2);
    vec_t t;
    t.cs = cs; t.rd = rd; t.wr = wr; t.ck = ck; t.rq = rq; t.addr = a; t.be = be; t.wd = wd;
    t.ew = ew; t.v1 = v1; t.d1 = d1; t.v2 = v2; t.d2 = d2;
    tbl.push_back(t);
  endtask

  task automatic add_idle(input logic v1, input logic [31:0] d1, input logic v2, input logic [31:0] d2);
    add(0, 0, 0, 1, 0, '0, 4'h0, 32'h0, 0, v1, d1, v2, d2);
  endtask

  task automatic add_wr(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] wd,
                        input logic v1, input logic [31:0] d1, input logic v2, input logic [31:0] d2);
    add(1, 0, 1, 1, 0, a, be, wd, 0, v1, d1, v2, d2);
  endtask

  task automatic add_rd(input logic [AW-1:0] a,
                        input logic v1, input logic [31:0] d1, input logic v2, input logic [31:0] d2);
    add(1, 1, 0, 1, 0, a, 4'h0, 32'h0, 0, v1, d1, v2, d2);
  endtask

  task automatic idle_inputs();
    chipselect = 0; read = 0; write = 0; clken = 1; reset_req = 0;
    address = '0; byteenable = '0; writedata = '0;
  endtask

  // Counts waitrequest-high cycles with clken=1 from reset release, with a
  // two-cycle stall inside the sweep. Stops when both instances are ready.
  task automatic sweep(output int n1, output int n2);
    n1 = 0; n2 = 0;
    for (int g = 0; g < 200; g++) begin
      clken = !(g == 3 || g == 4);
      #1;
      if (!wt1 && !wt2) break;
      if (clken && wt1) n1++;
      if (clken && wt2) n2++;
      step();
    end
    clken = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, n2, p1, p2, bad;

    // vector table, filled up front (expected: lat1 valid/data, lat2 valid/data)
    add_wr(0, 4'hF, 32'h000000A0, 0, 32'h0, 0, 32'h0);
    add_wr(1, 4'hF, 32'h000000A1, 0, 32'h0, 0, 32'h0);
    add_wr(2, 4'hF, 32'h000000A2, 0, 32'h0, 0, 32'h0);
    add_wr(3, 4'hF, 32'h000000A3, 0, 32'h0, 0, 32'h0);
    add_wr(5, 4'hF, 32'hDEADBEEF, 0, 32'h0, 0, 32'h0);
    add_wr(5, 4'h1, 32'h00000011, 0, 32'h0, 0, 32'h0);
    add_rd(5, 0, 32'h0, 0, 32'h0);
    add_idle(1, 32'hDEADBE11, 0, 32'h0);
    add_idle(0, 32'hDEADBE11, 1, 32'hDEADBE11);
    add_rd(0, 0, 32'hDEADBE11, 0, 32'hDEADBE11);
    add_rd(1, 1, 32'hA0, 0, 32'hDEADBE11);
    add_rd(2, 1, 32'hA1, 1, 32'hA0);
    add_rd(3, 1, 32'hA2, 1, 32'hA1);
    add_idle(1, 32'hA3, 1, 32'hA2);
    add_idle(0, 32'hA3, 1, 32'hA3);
    add_wr(7, 4'hF, 32'h12345678, 0, 32'hA3, 0, 32'hA3);
    add_rd(7, 0, 32'hA3, 0, 32'hA3);
    add_idle(1, 32'h12345678, 0, 32'hA3);
    add_idle(0, 32'h12345678, 1, 32'h12345678);
    add(1, 1, 1, 1, 0, 7, 4'h3, 32'h0000CAFE, 0, 0, 32'h12345678, 0, 32'h12345678);
    add_idle(0, 32'h12345678, 0, 32'h12345678);
    add_idle(0, 32'h12345678, 0, 32'h12345678);
    add_rd(7, 0, 32'h12345678, 0, 32'h12345678);
    add_idle(1, 32'h1234CAFE, 0, 32'h12345678);
    add_idle(0, 32'h1234CAFE, 1, 32'h1234CAFE);
    add_wr(1, 4'h0, 32'hFFFFFFFF, 0, 32'h1234CAFE, 0, 32'h1234CAFE);
    add(0, 1, 0, 1, 0, 1, 4'h0, 32'h0, 0, 0, 32'h1234CAFE, 0, 32'h1234CAFE);
    add_rd(1, 0, 32'h1234CAFE, 0, 32'h1234CAFE);
    add_idle(1, 32'hA1, 0, 32'h1234CAFE);
    add_idle(0, 32'hA1, 1, 32'hA1);
    add_rd(2, 0, 32'hA1, 0, 32'hA1);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 4'h0, 32'h0, 1, 0, 32'hA2, 0, 32'hA1);
    add_idle(1, 32'hA2, 0, 32'hA1);
    add_idle(0, 32'hA2, 1, 32'hA2);
    add_idle(0, 32'hA2, 0, 32'hA2);
    add(1, 1, 0, 1, 1, 3, 4'h0, 32'h0, 1, 0, 32'hA2, 0, 32'hA2);
    add_idle(0, 32'hA2, 0, 32'hA2);
    add_rd(0, 0, 32'hA2, 0, 32'hA2);
    add(0, 0, 0, 1, 1, 0, 4'h0, 32'h0, 1, 1, 32'hA0, 0, 32'hA2);
    add(1, 1, 0, 1, 1, 1, 4'h0, 32'h0, 1, 0, 32'hA0, 1, 32'hA0);
    add_idle(0, 32'hA0, 0, 32'hA0);
    add(1, 0, 1, 1, 1, 0, 4'hF, 32'hBAD00000, 1, 0, 32'hA0, 0, 32'hA0);
    add_rd(0, 0, 32'hA0, 0, 32'hA0);
    add_idle(1, 32'hA0, 0, 32'hA0);
    add_idle(0, 32'hA0, 1, 32'hA0);
    add(1, 0, 1, 0, 0, 0, 4'hF, 32'hBAD00000, 1, 0, 32'hA0, 0, 32'hA0);
    add_rd(0, 0, 32'hA0, 0, 32'hA0);
    add_idle(1, 32'hA0, 0, 32'hA0);
    add_idle(0, 32'hA0, 1, 32'hA0);

    // reset state
    idle_inputs();
    reset_n = 1;
    #1 reset_n = 0;
    step(); step(); step();
    #1;
    chk("reset rdata1", rd1, 32'h0);
    chk("reset rdata2", rd2, 32'h0);
    chk("reset rdv1", {31'b0, rv1}, 32'h0);
    chk("reset rdv2", {31'b0, rv2}, 32'h0);
    chk("reset wait1", {31'b0, wt1}, 32'h1);
    chk("reset wait2", {31'b0, wt2}, 32'h1);

    // zero-fill sweep after release
    step();
    reset_n = 1;
    sweep(n1, n2);
    chk("sweep cycles1", n1, 16);
    chk("sweep cycles2", n2, 16);
    step();

    // back-to-back reads of every address: all zero, one pulse each
    p1 = 0; p2 = 0; bad = 0;
    for (int c = 0; c < 18; c++) begin
      chipselect = (c < 16);
      read       = (c < 16);
      address    = c[AW-1:0];
      #1;
      if (rv1) begin p1++; if (rd1 !== 32'h0 || c < 1) bad++; end
      if (rv2) begin p2++; if (rd2 !== 32'h0 || c < 2) bad++; end
      step();
    end
    chk("zero reads pulses1", p1, 16);
    chk("zero reads pulses2", p2, 16);
    chk("zero reads bad data", bad, 0);

    // table-driven vectors
    foreach (tbl[i]) begin
      chipselect = tbl[i].cs; read = tbl[i].rd; write = tbl[i].wr;
      clken = tbl[i].ck; reset_req = tbl[i].rq; address = tbl[i].addr;
      byteenable = tbl[i].be; writedata = tbl[i].wd;
      #1;
      chk($sformatf("v%0d wait1", i), {31'b0, wt1}, {31'b0, tbl[i].ew});
      chk($sformatf("v%0d wait2", i), {31'b0, wt2}, {31'b0, tbl[i].ew});
      chk($sformatf("v%0d rdv1", i), {31'b0, rv1}, {31'b0, tbl[i].v1});
      chk($sformatf("v%0d rdv2", i), {31'b0, rv2}, {31'b0, tbl[i].v2});
      chk($sformatf("v%0d rdata1", i), rd1, tbl[i].d1);
      chk($sformatf("v%0d rdata2", i), rd2, tbl[i].d2);
      step();
    end
    idle_inputs();

    // asynchronous reset takes effect without a clock edge
    reset_n = 0;
    #1;
    chk("async rst rdata1", rd1, 32'h0);
    chk("async rst rdata2", rd2, 32'h0);
    chk("async rst wait1", {31'b0, wt1}, 32'h1);
    step();
    reset_n = 1;

    // abort the sweep at counter 7, then it must restart from 0
    for (int k = 0; k < 7; k++) begin
      #1;
      chk($sformatf("partial sweep wait c%0d", k), {31'b0, wt1}, 32'h1);
      step();
    end
    reset_n = 0;
    #1;
    chk("abort rdv1", {31'b0, rv1}, 32'h0);
    chk("abort wait2", {31'b0, wt2}, 32'h1);
    step();
    reset_n = 1;
    sweep(n1, n2);
    chk("restart sweep cycles1", n1, 16);
    chk("restart sweep cycles2", n2, 16);
    step();

    // previously written addresses must now read back as zero
    chipselect = 1; read = 1; address = 0;
    step();
    address = 7;
    #1;
    chk("post sweep rdv1 a0", {31'b0, rv1}, 32'h1);
    chk("post sweep rdata1 a0", rd1, 32'h0);
    step();
    idle_inputs();
    #1;
    chk("post sweep rdv1 a7", {31'b0, rv1}, 32'h1);
    chk("post sweep rdata1 a7", rd1, 32'h0);
    step();
    #1;
    chk("post sweep rdv2 a7", {31'b0, rv2}, 32'h1);
    chk("post sweep rdata2 a7", rd2, 32'h0);
    step();

`ifdef OCM_PARITY_EN
    // stored-bit corruption is reported on the response cycle and sticks
    chipselect = 1; write = 1; address = 9; byteenable = 4'hF; writedata = 32'h000000FF;
    step();
    idle_inputs();
    #1;
    chk("parity clean1", {31'b0, pe1}, 32'h0);
    dut1.u_ram.mem[9][0] = 1'b0;
    dut2.u_ram.mem[9][0] = 1'b0;
    step();
    chipselect = 1; read = 1; address = 9;
    step();
    idle_inputs();
    #1;
    chk("parity rdv1", {31'b0, rv1}, 32'h1);
    chk("parity err1 on rdv", {31'b0, pe1}, 32'h1);
    chk("parity data1 unmodified", rd1, 32'h000000FE);
    chk("parity err2 early", {31'b0, pe2}, 32'h0);
    step();
    #1;
    chk("parity err2 on rdv", {31'b0, pe2}, 32'h1);
    chk("parity err1 sticky", {31'b0, pe1}, 32'h1);
    step(); step();
    #1;
    chk("parity err1 still", {31'b0, pe1}, 32'h1);
    reset_n = 0;
    #1;
    chk("parity err1 reset", {31'b0, pe1}, 32'h0);
    chk("parity err2 reset", {31'b0, pe2}, 32'h0);
    step();
    reset_n = 1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ocm_avalon_pipelined.md
Name: ocm_avalon_pipelined

Overview:
Parametrised on-chip memory Avalon-MM slave. Successor to the fixed 8K x 32 single-port RAM slave. Adds configurable width, depth and read latency, pipelined reads with readdatavalid, and an optional post-reset zero-fill sweep. Sits on the Nios II data/instruction interconnect as program/data RAM or scratch buffer.

Parameters:
DATA_W, 32, data width in bits; multiple of 8
ADDR_W, 13, word address width; depth = 2**ADDR_W
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2
INIT_CLEAR, 0, 1 = zero-fill whole array after reset, 0 = no sweep
INIT_FILE, "", hex preload for synthesis/simulation; ignored when INIT_CLEAR=1

Ports:
clk  in  1  single clock
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_W  word address
byteenable  in  DATA_W/8  byte lanes for writes
chipselect  in  1  slave select
read  in  1  read request
write  in  1  write request
writedata  in  DATA_W  write data
clken  in  1  global clock enable; low = stall
reset_req  in  1  reset-request quiesce; blocks RAM access
readdata  out  DATA_W  read data
readdatavalid  out  1  one-cycle qualifier for readdata
waitrequest  out  1  high = request not accepted

Behaviour:
- Reset (reset_n low, async): readdata=0, readdatavalid=0, waitrequest=1, pipeline valids cleared, clear counter=0. FSM goes to CLEAR if INIT_CLEAR=1, otherwise READY.
- FSM has three states: RESET, CLEAR and READY.
  - RESET: entered only while reset_n is low.
  - CLEAR: waitrequest=1. Writes zero, all bytes, to counter address. Counter advances by 1 per cycle when clken=1. On the cycle it writes address 2**ADDR_W-1, the next state is READY. Takes exactly 2**ADDR_W enabled cycles.
  - READY: waitrequest=0 whenever reset_req=0 and clken=1; otherwise 1.
- Reset asserted mid-CLEAR aborts the sweep. After release, the sweep restarts from address 0.
- Accept conditions:
  - write_acc = READY & chipselect & write & clken & ~reset_req.
  - read_acc = READY & chipselect & read & ~write & clken & ~reset_req.
- Write: only lanes with byteenable=1 are updated, at the accepted edge. byteenable=0 means no change. No response is generated.
- read and write asserted together: the write is performed and the read is dropped (no readdatavalid).
- Read:
  - Latency 1: RAM output register. readdata and readdatavalid appear on the first edge after acceptance.
  - Latency 2: an extra output register is added.
  - One read may be accepted per cycle, with no back-to-back bubbles. Responses stay in order.
- Read-after-write to the same address on the next cycle returns the new data.
- Stall: clken=0 freezes all pipeline stages, readdata, the FSM and the counter. readdatavalid is forced to 0 while clken=0. A pending response is emitted on the first cycle after clken returns to 1.
- reset_req=1 blocks new accepts. In-flight reads still complete; they advance only when clken=1.
- readdata holds its last value when readdatavalid=0.
- Address is unsigned with no wrap logic; the counter alone wraps at 2**ADDR_W.

Optional Feature:
OCM_PARITY_EN
- Defined:
  - Stores one even-parity bit per byte lane, computed at write time (zero-fill writes parity 0).
  - On each read response, recomputes parity and compares it.
  - New output parity_err (1 bit) is a sticky flag, set on the readdatavalid cycle with any mismatch.
  - parity_err is cleared only by reset_n. Data is still returned unmodified.
- Undefined: no parity storage, no parity_err port; RAM width = DATA_W.

Decomposition:
- Package ocm_pkg holds:
  - FSM state enum (ST_RESET, ST_CLEAR, ST_READY).
  - Legal READ_LATENCY constants.
  - Function returning byte-lane count DATA_W/8.
  - Parity-width function.
- Sub-module ocm_ram_core: inferred byte-enabled single-port RAM with registered read and INIT_FILE hook. Width is DATA_W, or DATA_W+DATA_W/8 when OCM_PARITY_EN is defined.
- Top level holds the FSM, accept logic, latency pipeline and parity check.

Test Plan:
- INIT_CLEAR=1, ADDR_W=4, after reset release: waitrequest stays 1 for exactly 16 clken cycles, then 0. Reads of all 16 addresses return 0x00000000.
- Write 0xDEADBEEF to addr 5 with byteenable 0xF, then write 0x00000011 to addr 5 with byteenable 0x1, then read: 0xDEADBE11 appears 1 cycle later (READ_LATENCY=1) or 2 cycles later (READ_LATENCY=2).
- READ_LATENCY=2, back-to-back reads of addrs 0,1,2,3 holding 0xA0..0xA3: four consecutive readdatavalid pulses, in order, starting 2 cycles after the first accept.
- Read accepted, then clken=0 for 3 cycles: readdatavalid stays 0 throughout. Correct data with readdatavalid=1 appears on the first cycle after clken=1; no duplicate pulse.
- reset_n pulsed low at clear-counter address 7 (ADDR_W=4): outputs return to reset values immediately. Sweep restarts and takes a full 16 cycles.
- OCM_PARITY_EN: write 0x000000FF; testbench flips a stored data bit via hierarchical force, then reads: parity_err rises on the readdatavalid cycle and stays high until reset_n.
